// File: rtl/reg_addr_seq_sel.sv
// reg_addr_seq_sel: registered register-address mux plus block-transfer list sequencer.
// Define REG_ADDR_SEQ_SEL_DESC_EN to allow descending list order (ir[23]=0 at start).
module reg_addr_seq_sel #(
  parameter int AW     = 4,
  parameter int NREG   = 16,
  parameter int IRW    = 32,
  parameter int PC_IDX = 15,
  parameter int LR_IDX = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IRW-1:0] ir,
  input  logic [2:0]     sel,
  input  logic           start,
  input  logic           step,
  output logic [AW-1:0]  out,
  output logic           valid,
  output logic           busy,
  output logic           done,
  output logic [AW:0]    count
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [NREG-1:0] mask_q, mask_d, src_mask;
  logic [AW-1:0] out_q, out_d, idx, fld;
  logic valid_q, valid_d, done_q, done_d;
  logic [AW:0] count_q, count_d;
  logic unused_ir;
  assign unused_ir = ^ir;
  function automatic logic [AW-1:0] lo_idx(input logic [NREG-1:0] m);
    lo_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) if (m[i]) lo_idx = AW'(i);
  endfunction
`ifdef REG_ADDR_SEQ_SEL_DESC_EN
  logic desc_q, desc_d;
  function automatic logic [AW-1:0] hi_idx(input logic [NREG-1:0] m);
    hi_idx = '0;
    for (int i = 0; i < NREG; i++) if (m[i]) hi_idx = AW'(i);
  endfunction
`endif
  // In IDLE the encoder looks at the incoming list so the first address lands with start.
  always_comb begin
    src_mask = (state_q == IDLE) ? ir[NREG-1:0] : mask_q;
`ifdef REG_ADDR_SEQ_SEL_DESC_EN
    desc_d = (state_q == IDLE) ? ~ir[23] : desc_q;
    idx    = desc_d ? hi_idx(src_mask) : lo_idx(src_mask);
`else
    idx    = lo_idx(src_mask);
`endif
    fld = (sel == 3'd0) ? AW'(ir[19:16]) :
          (sel == 3'd1) ? AW'(ir[15:12]) :
          (sel == 3'd2) ? AW'(ir[3:0])   :
          (sel == 3'd3) ? AW'(PC_IDX)    : AW'(LR_IDX);
  end
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    out_d   = out_q;
    valid_d = valid_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (sel < 3'd5) begin
        out_d   = fld;
        valid_d = 1'b1;
      end else if (sel == 3'd5 && start) begin
        count_d = '0;
        valid_d = 1'b0;
        mask_d  = src_mask & ~(NREG'(1) << idx);
        if (src_mask != '0) begin
          out_d   = idx;
          valid_d = 1'b1;
          count_d = (AW+1)'(1);
          state_d = RUN;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        valid_d = 1'b0;
      end
    end else if (step) begin
      if (mask_q != '0) begin
        out_d   = idx;
        mask_d  = mask_q & ~(NREG'(1) << idx);
        count_d = count_q + (AW+1)'(1);
      end else begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end
`ifdef REG_ADDR_SEQ_SEL_DESC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) desc_q <= 1'b0;
    else if (state_q == IDLE) desc_q <= desc_d;
  end
`endif
  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign count = count_q;
endmodule
